cpu_fetch_unit: RTL
===================

CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 Clk  input  1  single system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset; sampled on rising edge of Clk only.
REQ-003 PS  input  2  PC select from decoder: 00 hold, 01 PC+1, 10 PC+1+sext(IR[7:0]), 11 load Branch_Addr.
REQ-004 IR_L  input  1  from decoder: 1 = fetch next instruction after this execute cycle; 0 = hold IR.
REQ-005 NS  input  1  decoder next-state bit for multi-cycle instructions.
REQ-006 Branch_Addr  input  16  absolute target from datapath, used when PS=11.
REQ-007 IMem_Data  input  16  instruction word from instruction memory.
REQ-008 IMem_Ack  input  1  memory response valid; IMem_Data valid in same cycle.
REQ-009 IMem_Req  output  1  fetch request to instruction memory.
REQ-010 IMem_Addr  output  16  fetch address; equals PC.
REQ-011 IR  output  16  registered instruction word to decoder.
REQ-012 PC  output  16  program counter.
REQ-013 State  output  1  registered micro-step bit to decoder.
REQ-014 Exec_Valid  output  1  1 only while IR holds a valid instruction being executed; gates datapath WR/MemWrite.

Function
REQ-015 FSM states SHALL be RESET_WAIT, FETCH, EXEC; encoding is free.
REQ-016 RESET_WAIT: all outputs at reset values for exactly one cycle, then -> FETCH.
REQ-017 FETCH: IMem_Req=1, IMem_Addr=PC, Exec_Valid=0; PC, State held.
REQ-018 FETCH with IMem_Ack=1: IR <= IMem_Data, State <= 0, -> EXEC on same edge; Ack=0 -> remain FETCH indefinitely (no timeout).
REQ-019 IMem_Ack while not in FETCH SHALL be ignored; IR unchanged.
REQ-020 EXEC: IMem_Req=0, Exec_Valid=1; one decoder evaluation per cycle.
REQ-021 EXEC, NS=1: State <= 1, PC held regardless of PS, IR held, remain EXEC.
REQ-022 EXEC, NS=0: State <= 0, PC updated per PS (REQ-003) on that edge.
REQ-023 EXEC, NS=0, IR_L=1 -> FETCH next cycle (fetch uses updated PC).
REQ-024 EXEC, NS=0, IR_L=0 -> remain EXEC with IR unchanged (instruction re-executes with updated PC/State).
REQ-025 PC arithmetic modulo 2^16: 0xFFFF+1 = 0x0000; PS=10 adds sign-extended 8-bit offset to PC+1 with wrap (e.g. PC=0x0000, offset 0xFE -> 0xFFFF).
REQ-026 PS sampled only in EXEC with NS=0; ignored in RESET_WAIT and FETCH.
REQ-027 IMem_Addr SHALL equal PC combinationally in every state.
REQ-028 One instruction latency minimum: Ack edge -> first EXEC cycle immediately following; single-cycle instruction with zero-wait memory completes in 2 cycles (FETCH+EXEC).

Reset
REQ-029 Reset=1 at a rising edge SHALL force: PC=0x0000, IR=0x0000, State=0, IMem_Req=0, Exec_Valid=0, FSM=RESET_WAIT, regardless of current state.
REQ-030 Reset during FETCH abandons the request; a same-cycle IMem_Ack SHALL NOT load IR.
REQ-031 Reset has priority over every other input; no output is X after first Reset edge.

Verification
REQ-032 Reset, zero-wait memory returning 0xA123 at addr 0, PS=01, IR_L=1, NS=0 -> IR=0xA123 in EXEC, PC=0x0001 at next FETCH, IMem_Addr=0x0001.
REQ-033 Ack delayed 3 cycles in FETCH -> IMem_Req held 1 with IMem_Addr stable for 4 cycles, Exec_Valid=0 throughout, IR loads on the Ack cycle only.
REQ-034 PC=0x0010, EXEC with NS=1 then NS=0/PS=11/Branch_Addr=0x0200 -> State 0->1->0, PC stays 0x0010 for first EXEC, becomes 0x0200, next fetch from 0x0200.
REQ-035 PC=0x0005, PS=10, IR[7:0]=0xFC -> PC=0x0002; PC=0xFFFF, PS=01 -> PC=0x0000.
REQ-036 EXEC with IR_L=0, NS=0, PS=00 for 3 cycles -> no IMem_Req, IR and PC constant, Exec_Valid=1 each cycle.
REQ-037 Reset asserted in FETCH coincident with IMem_Ack=1, IMem_Data=0xBEEF -> IR=0x0000, PC=0x0000, one RESET_WAIT cycle, then fetch from 0x0000.

Source files
------------

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch/sequencing unit: holds PC and IR, issues fetch requests,
// and steps the decoder through multi-cycle instructions.
module cpu_fetch_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  PS,
    input  logic        IR_L,
    input  logic        NS,
    input  logic [15:0] Branch_Addr,
    input  logic [15:0] IMem_Data,
    input  logic        IMem_Ack,
    output logic        IMem_Req,
    output logic [15:0] IMem_Addr,
    output logic [15:0] IR,
    output logic [15:0] PC,
    output logic        State,
    output logic        Exec_Valid
);

    typedef enum logic [1:0] {
        RESET_WAIT,
        FETCH,
        EXEC
    } fsm_t;

    typedef enum logic [1:0] {
        PS_HOLD   = 2'b00,
        PS_INC    = 2'b01,
        PS_REL    = 2'b10,
        PS_BRANCH = 2'b11
    } pc_sel_t;

    fsm_t        fsm_q, fsm_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        step_q, step_d;

    logic [15:0] pc_inc;
    logic [15:0] pc_rel;
    logic [15:0] pc_sel;

    // Candidate PC values; all arithmetic wraps at 16 bits.
    always_comb begin
        pc_inc = pc_q + 16'd1;
        pc_rel = pc_inc + {{8{ir_q[7]}}, ir_q[7:0]};
        pc_sel = pc_q;
        case (pc_sel_t'(PS))
            PS_HOLD:   pc_sel = pc_q;
            PS_INC:    pc_sel = pc_inc;
            PS_REL:    pc_sel = pc_rel;
            PS_BRANCH: pc_sel = Branch_Addr;
            default:   pc_sel = pc_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsm_q  <= RESET_WAIT;
            pc_q   <= '0;
            ir_q   <= '0;
            step_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            step_q <= step_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        step_d     = step_q;
        IMem_Req   = 1'b0;
        Exec_Valid = 1'b0;

        case (fsm_q)
            RESET_WAIT: begin
                fsm_d = FETCH;
            end

            FETCH: begin
                IMem_Req = 1'b1;
                if (IMem_Ack) begin
                    ir_d   = IMem_Data;
                    step_d = 1'b0;
                    fsm_d  = EXEC;
                end
            end

            EXEC: begin
                Exec_Valid = 1'b1;
                if (NS) begin
                    step_d = 1'b1;
                end else begin
                    step_d = 1'b0;
                    pc_d   = pc_sel;
                    if (IR_L)
                        fsm_d = FETCH;
                end
            end

            default: begin
                fsm_d = RESET_WAIT;
            end
        endcase
    end

    assign IMem_Addr = pc_q;
    assign PC        = pc_q;
    assign IR        = ir_q;
    assign State     = step_q;

endmodule
